// File: rtl/ctrl_pkg.sv
// Shared opcodes, read-latency limits and state encoding for the data-memory control unit.
package ctrl_pkg;

  localparam logic [3:0] OPC_STORE = 4'b1100;
  localparam logic [3:0] OPC_LOAD  = 4'b1101;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;
  localparam int CNT_W      = $clog2(RD_LAT_MAX);

  typedef enum logic [2:0] {
    IDLE,
    STORE,
    LOAD_REQ,
    LOAD_WAIT,
    LOAD_CAP,
    RETIRE
  } state_e;

endpackage

// File: rtl/rd_latency_counter.sv
// Loadable down-counter for the RAM read wait; zero flag is combinational from the count.
// Decrement saturates at zero, so the flag stays high until the next load.
module rd_latency_counter
  import ctrl_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mem_control_unit.sv
// Data-memory sequencer: STORE retires 2 cycles after accept, LOAD 2+RD_LAT, ALU-only ops 1.
// One instruction in flight; instr_ready is low from accept until the FSM is back in IDLE.
module mem_control_unit #(
  parameter int               DATA_W    = 8,
  parameter int               ADDR_W    = 4,
  parameter int               OPC_W     = 4,
  parameter int               RD_LAT    = 1,
  parameter logic [OPC_W-1:0] OPC_STORE = OPC_W'(ctrl_pkg::OPC_STORE),
  parameter logic [OPC_W-1:0] OPC_LOAD  = OPC_W'(ctrl_pkg::OPC_LOAD)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [OPC_W-1:0]  opcode,
  input  logic [ADDR_W-1:0] operando,
  input  logic [DATA_W-1:0] alu_result,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic [DATA_W-1:0] reg_a,
  output logic [DATA_W-1:0] led_out,
  output logic              done
);
  import ctrl_pkg::*;

  if ((RD_LAT < RD_LAT_MIN) || (RD_LAT > RD_LAT_MAX)) begin : g_rd_lat_check
    $error("mem_control_unit: RD_LAT must lie in 1..4");
  end

  state_e            state;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] dat_q;
  logic              accept;
  logic              cnt_zero;

  assign instr_ready = (state == IDLE) && !reset;
  assign accept      = instr_valid && instr_ready;

  // Address and write data are latched at accept, so they stay put while the decoder moves on.
  assign mem_addr = addr_q;
  assign mem_din  = dat_q;

  rd_latency_counter u_rd_latency_counter (
    .clock    (clock),
    .reset    (reset),
    .load     (accept && (opcode == OPC_LOAD)),
    .load_val (CNT_W'(RD_LAT - 1)),
    .dec      ((state == LOAD_REQ) || (state == LOAD_WAIT)),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      addr_q  <= '0;
      dat_q   <= '0;
      mem_rd  <= 1'b0;
      mem_we  <= 1'b0;
      done    <= 1'b0;
      reg_a   <= '0;
      led_out <= '0;
    end else begin
      mem_rd <= 1'b0;
      mem_we <= 1'b0;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            addr_q <= operando;
            dat_q  <= alu_result;
            if (opcode == OPC_STORE) begin
              mem_we <= 1'b1;
              state  <= STORE;
            end else if (opcode == OPC_LOAD) begin
              mem_rd <= 1'b1;
              state  <= LOAD_REQ;
            end else begin
              done  <= 1'b1;
              state <= RETIRE;
            end
          end
        end
        STORE: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        // With RD_LAT=1 the counter is already zero here and LOAD_WAIT is skipped.
        LOAD_REQ:  state <= cnt_zero ? LOAD_CAP : LOAD_WAIT;
        LOAD_WAIT: if (cnt_zero) state <= LOAD_CAP;
        LOAD_CAP: begin
          reg_a   <= mem_dout;
          led_out <= mem_dout;
          done    <= 1'b1;
          state   <= IDLE;
        end
        RETIRE:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_control_unit.sv
// Bench for mem_control_unit: two instances (RD_LAT=1 and RD_LAT=3) against a latency-accurate RAM
// and a transaction-level reference model of retire timing and memory contents.
module tb_mem_control_unit;
  import ctrl_pkg::*;

  typedef struct packed {
    logic [3:0] opc;
    logic [3:0] addr;
    logic [7:0] dat;
  } instr_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset       [2];
  logic       instr_valid [2];
  logic       instr_ready [2];
  logic [3:0] opcode      [2];
  logic [3:0] operando    [2];
  logic [7:0] alu_result  [2];
  logic [3:0] mem_addr    [2];
  logic       mem_rd      [2];
  logic       mem_we      [2];
  logic [7:0] mem_din     [2];
  logic [7:0] mem_dout    [2];
  logic [7:0] reg_a       [2];
  logic [7:0] led_out     [2];
  logic       done        [2];

  logic [7:0] ram       [2][16];
  logic [3:0] rd_sh     [2];
  logic [3:0] ad_sh     [2][4];
  logic [7:0] junk      [2];
  logic [7:0] model_mem [2][16];
  instr_t     prog[$];
  int         n_total = 0;
  int         n_pass  = 0;
  int         last_span;

  function automatic int lat(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : 3;
    mem_control_unit #(.DATA_W(8), .ADDR_W(4), .OPC_W(4), .RD_LAT(L)) u_dut (
      .clock       (clock),
      .reset       (reset[g]),
      .instr_valid (instr_valid[g]),
      .instr_ready (instr_ready[g]),
      .opcode      (opcode[g]),
      .operando    (operando[g]),
      .alu_result  (alu_result[g]),
      .mem_addr    (mem_addr[g]),
      .mem_rd      (mem_rd[g]),
      .mem_we      (mem_we[g]),
      .mem_din     (mem_din[g]),
      .mem_dout    (mem_dout[g]),
      .reg_a       (reg_a[g]),
      .led_out     (led_out[g]),
      .done        (done[g])
    );
    // Read data is only genuine in the cycle RD_LAT after the strobe; otherwise random junk.
    assign mem_dout[g] = rd_sh[g][L-1] ? ram[g][ad_sh[g][L-1]] : junk[g];
  end

  always @(posedge clock) begin
    for (int k = 0; k < 2; k++) begin
      junk[k]     <= 8'($urandom);
      rd_sh[k]    <= reset[k] ? 4'h0 : {rd_sh[k][2:0], mem_rd[k]};
      ad_sh[k][0] <= mem_addr[k];
      for (int s = 1; s < 4; s++) ad_sh[k][s] <= ad_sh[k][s-1];
      if (reset[k]) begin
        for (int a = 0; a < 16; a++) ram[k][a] <= 8'h00;
      end else if (mem_we[k]) begin
        ram[k][mem_addr[k]] <= mem_din[k];
      end
    end
  end

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      reset[k] = 1'b1; instr_valid[k] = 1'b0; opcode[k] = 4'h0; operando[k] = 4'h0; alu_result[k] = 8'h00;
    end
    repeat (3) @(negedge clock);
    for (int k = 0; k < 2; k++) begin
      n_total++;
      if ({mem_rd[k], mem_we[k], done[k], instr_ready[k]} !== 4'b0000)
        $display("FAIL reset_ctl[%0d]: got %b expected 0000", k, {mem_rd[k], mem_we[k], done[k], instr_ready[k]});
      else n_pass++;
      n_total++;
      if ({mem_addr[k], mem_din[k], reg_a[k], led_out[k]} !== 28'h0)
        $display("FAIL reset_data[%0d]: got %h expected 0", k, {mem_addr[k], mem_din[k], reg_a[k], led_out[k]});
      else n_pass++;
      for (int a = 0; a < 16; a++) model_mem[k][a] = 8'h00;
      reset[k] = 1'b0;
    end
    @(negedge clock);
    for (int k = 0; k < 2; k++) begin
      n_total++;
      if ({instr_ready[k], done[k]} !== 2'b10)
        $display("FAIL reset_release[%0d]: ready/done got %b expected 10", k, {instr_ready[k], done[k]});
      else n_pass++;
    end
  endtask

  task automatic test_store(input int i, input logic [3:0] a, input logic [7:0] d);
    @(negedge clock);
    n_total++;
    if (instr_ready[i] !== 1'b1) $display("FAIL store_ready[%0d]: got %b expected 1", i, instr_ready[i]);
    else n_pass++;
    opcode[i] = OPC_STORE; operando[i] = a; alu_result[i] = d; instr_valid[i] = 1'b1;
    @(negedge clock);
    instr_valid[i] = 1'b0; alu_result[i] = 8'h00;
    n_total++;
    if ({mem_we[i], mem_rd[i], done[i], instr_ready[i]} !== 4'b1000)
      $display("FAIL store_c1_ctl[%0d]: we/rd/done/ready got %b expected 1000", i, {mem_we[i], mem_rd[i], done[i], instr_ready[i]});
    else n_pass++;
    n_total++;
    if ({mem_addr[i], mem_din[i]} !== {a, d})
      $display("FAIL store_c1_addr_din[%0d]: got %h expected %h", i, {mem_addr[i], mem_din[i]}, {a, d});
    else n_pass++;
    @(negedge clock);
    n_total++;
    if ({mem_we[i], mem_rd[i], done[i], instr_ready[i]} !== 4'b0011)
      $display("FAIL store_c2_ctl[%0d]: we/rd/done/ready got %b expected 0011", i, {mem_we[i], mem_rd[i], done[i], instr_ready[i]});
    else n_pass++;
    n_total++;
    if ((mem_din[i] !== d) || (ram[i][a] !== d))
      $display("FAIL store_data_hold[%0d]: din %h ram %h expected %h", i, mem_din[i], ram[i][a], d);
    else n_pass++;
    model_mem[i][a] = d;
  endtask

  task automatic test_load(input int i, input logic [3:0] a, input logic [7:0] d, input bit pulses);
    int L = lat(i);
    @(negedge clock);
    n_total++;
    if (instr_ready[i] !== 1'b1) $display("FAIL load_ready[%0d]: got %b expected 1", i, instr_ready[i]);
    else n_pass++;
    opcode[i] = OPC_LOAD; operando[i] = a; alu_result[i] = 8'($urandom); instr_valid[i] = 1'b1;
    for (int k = 1; k <= 2 + L; k++) begin
      @(negedge clock);
      n_total++;
      if ({mem_rd[i], mem_we[i], done[i], instr_ready[i]} !== {k == 1, 1'b0, k == 2 + L, k == 2 + L})
        $display("FAIL load_ctl[%0d] cycle %0d: rd/we/done/ready got %b expected %b", i, k,
                 {mem_rd[i], mem_we[i], done[i], instr_ready[i]}, {k == 1, 1'b0, k == 2 + L, k == 2 + L});
      else n_pass++;
      n_total++;
      if (mem_addr[i] !== a) $display("FAIL load_addr[%0d] cycle %0d: got %h expected %h", i, k, mem_addr[i], a);
      else n_pass++;
      if (k == 2 + L) begin
        n_total++;
        if ((reg_a[i] !== d) || (led_out[i] !== d))
          $display("FAIL load_data[%0d]: reg_a %h led_out %h expected %h", i, reg_a[i], led_out[i], d);
        else n_pass++;
      end
      // While busy, stray STORE requests to another address must be ignored.
      instr_valid[i] = pulses && (k <= 1 + L) && k[0];
      opcode[i] = OPC_STORE; operando[i] = ~a;
    end
    instr_valid[i] = 1'b0;
  endtask

  task automatic run_stream(input int i, input bit rnd, input int n);
    int L = lat(i);
    int c = 0, ready_at = 0, done_at = -1, we_at = -1, rd_at = -1, first_acc = -1;
    int acc = 0, dones = 0, limit;
    bit have = 1'b0, ld = 1'b0, prev_rd = 1'b0, prev_we = 1'b0;
    instr_t cur = '0, act = '0;
    logic [7:0] exp_val = 8'h00;
    limit = n * (4 + L) * 3 + 20;
    last_span = -1;
    while (((acc < n) || (c <= done_at)) && (c < limit)) begin
      @(negedge clock);
      n_total++;
      if (instr_ready[i] !== (c >= ready_at))
        $display("FAIL stream_ready[%0d] c=%0d: got %b expected %b", i, c, instr_ready[i], c >= ready_at);
      else n_pass++;
      n_total++;
      if ({mem_we[i], mem_rd[i], done[i]} !== {c == we_at, c == rd_at, c == done_at})
        $display("FAIL stream_strobes[%0d] c=%0d: we/rd/done got %b expected %b", i, c,
                 {mem_we[i], mem_rd[i], done[i]}, {c == we_at, c == rd_at, c == done_at});
      else n_pass++;
      n_total++;
      if ((mem_we[i] && mem_rd[i]) || (mem_we[i] && prev_we) || (mem_rd[i] && prev_rd))
        $display("FAIL strobe_rule[%0d] c=%0d: we %b rd %b prev_we %b prev_rd %b expected exclusive single pulses",
                 i, c, mem_we[i], mem_rd[i], prev_we, prev_rd);
      else n_pass++;
      if ((c == we_at) || (ld && (c >= rd_at) && (c <= done_at))) begin
        n_total++;
        if ((mem_addr[i] !== act.addr) || ((c == we_at) && (mem_din[i] !== act.dat)))
          $display("FAIL stream_addr[%0d] c=%0d: addr %h din %h expected %h %h", i, c, mem_addr[i], mem_din[i], act.addr, act.dat);
        else n_pass++;
      end
      if ((c == done_at) && ld) begin
        n_total++;
        if ((reg_a[i] !== exp_val) || (led_out[i] !== exp_val))
          $display("FAIL stream_load[%0d] c=%0d: reg_a %h led_out %h expected %h", i, c, reg_a[i], led_out[i], exp_val);
        else n_pass++;
      end
      if (done[i] === 1'b1) dones++;
      if (c == done_at) last_span = c - first_acc;
      prev_we = mem_we[i];
      prev_rd = mem_rd[i];
      if (!have && (acc < n) && (!rnd || ($urandom_range(0, 2) != 0))) begin
        if (rnd) begin
          case ($urandom_range(0, 2))
            0:       cur.opc = OPC_STORE;
            1:       cur.opc = OPC_LOAD;
            default: begin
              cur.opc = 4'($urandom);
              if ((cur.opc == OPC_STORE) || (cur.opc == OPC_LOAD)) cur.opc = 4'b0010;
            end
          endcase
          cur.addr = 4'($urandom);
          cur.dat  = 8'($urandom);
        end else begin
          cur = prog[acc];
        end
        have = 1'b1;
      end
      instr_valid[i] = have;
      opcode[i]      = cur.opc;
      operando[i]    = cur.addr;
      alu_result[i]  = have ? cur.dat : 8'($urandom);
      if (have && (c >= ready_at)) begin
        act  = cur;
        have = 1'b0;
        acc++;
        if (first_acc < 0) first_acc = c;
        ld = 1'b0;
        if (cur.opc == OPC_STORE) begin
          we_at = c + 1; done_at = c + 2; ready_at = c + 2;
          model_mem[i][cur.addr] = cur.dat;
        end else if (cur.opc == OPC_LOAD) begin
          rd_at = c + 1; done_at = c + 2 + L; ready_at = c + 2 + L;
          ld = 1'b1;
          exp_val = model_mem[i][cur.addr];
        end else begin
          done_at = c + 1; ready_at = c + 2;
        end
      end
      c++;
    end
    instr_valid[i] = 1'b0;
    n_total++;
    if (c >= limit) $display("FAIL stream_timeout[%0d]: %0d cycles used, budget %0d", i, c, limit);
    else n_pass++;
    n_total++;
    if (dones !== acc) $display("FAIL done_count[%0d]: got %0d dones expected %0d", i, dones, acc);
    else n_pass++;
  endtask

  task automatic test_back_to_back(input int i);
    logic [7:0] d = 8'($urandom);
    prog.delete();
    prog.push_back('{OPC_STORE, 4'h9, d});
    prog.push_back('{4'b0010, 4'h2, 8'h55});
    prog.push_back('{OPC_LOAD, 4'h9, 8'h00});
    run_stream(i, 1'b0, 3);
    n_total++;
    if (last_span !== 6 + lat(i))
      $display("FAIL b2b_span[%0d]: first accept to last done got %0d expected %0d", i, last_span, 6 + lat(i));
    else n_pass++;
    n_total++;
    if ((reg_a[i] !== d) || (led_out[i] !== d))
      $display("FAIL b2b_roundtrip[%0d]: reg_a %h led_out %h expected %h", i, reg_a[i], led_out[i], d);
    else n_pass++;
  endtask

  task automatic test_reset_mid_load(input int i);
    test_store(i, 4'h7, 8'h5A);
    @(negedge clock);
    opcode[i] = OPC_LOAD; operando[i] = 4'h7; instr_valid[i] = 1'b1;
    @(negedge clock);
    instr_valid[i] = 1'b0;
    n_total++;
    if (mem_rd[i] !== 1'b1) $display("FAIL midrst_rd[%0d]: got %b expected 1", i, mem_rd[i]);
    else n_pass++;
    @(negedge clock);
    reset[i] = 1'b1;
    @(negedge clock);
    n_total++;
    if ({mem_rd[i], mem_we[i], done[i], instr_ready[i]} !== 4'b0000)
      $display("FAIL midrst_ctl[%0d]: got %b expected 0000", i, {mem_rd[i], mem_we[i], done[i], instr_ready[i]});
    else n_pass++;
    n_total++;
    if ({mem_addr[i], mem_din[i], reg_a[i], led_out[i]} !== 28'h0)
      $display("FAIL midrst_data[%0d]: got %h expected 0", i, {mem_addr[i], mem_din[i], reg_a[i], led_out[i]});
    else n_pass++;
    reset[i] = 1'b0;
    for (int a = 0; a < 16; a++) model_mem[i][a] = 8'h00;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      n_total++;
      if ({done[i], mem_rd[i], instr_ready[i], reg_a[i], led_out[i]} !== {1'b0, 1'b0, 1'b1, 8'h00, 8'h00})
        $display("FAIL midrst_after[%0d] cycle %0d: done/rd/ready/reg_a/led got %h expected 10000", i, k,
                 {done[i], mem_rd[i], instr_ready[i], reg_a[i], led_out[i]});
      else n_pass++;
    end
  endtask

  task automatic test_random(input int i, input int n);
    run_stream(i, 1'b1, n);
  endtask

  initial begin
    test_reset();
    test_store(0, 4'h5, 8'hA7);
    test_store(0, 4'h3, 8'h3C);
    test_load(0, 4'h3, 8'h3C, 1'b0);
    test_store(1, 4'hF, 8'hE1);
    test_load(1, 4'hF, 8'hE1, 1'b1);
    test_back_to_back(0);
    test_back_to_back(1);
    test_reset_mid_load(1);
    test_random(0, 60);
    test_random(1, 60);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary within the time limit");
    $fatal(1);
  end

endmodule
